display_frame_sequencer: RTL and testbench

DISPLAY_FRAME_SEQUENCER -- requirements
Module: display_frame_sequencer

---
 rtl/display_pkg.sv | 32 +++
 rtl/rnd_packer.sv | 47 ++++
 rtl/display_frame_sequencer.sv | 153 +++++++++++++++
 tb/tb_display_frame_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// ============================================================================
// Module   : display_pkg
// Purpose  : Shared state encoding, default parameters and sizing helper
//            for the display frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

    localparam int DEF_NB_SEG  = 28;
    localparam int DEF_RNDSIZE = 16;
    localparam int DEF_RND_W   = 8;
    localparam int DEF_NB_PIX  = 1920;
    localparam int DEF_FRAMES  = 4;
    localparam int DEF_DP_LAT  = 0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GATHER = 2'd1;
    localparam logic [1:0] ST_EVAL   = 2'd2;
    localparam logic [1:0] ST_OUT    = 2'd3;

    typedef logic [1:0] state_t;

    // Counter width able to hold 0..limit-1, never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rnd_packer.sv
// ============================================================================
// Module   : rnd_packer
// Purpose  : Counts RNG beats and packs beat k into dp_rnd[k*RND_W +: RND_W].
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rnd_packer
    import display_pkg::*;
#(
    parameter int RNDSIZE = DEF_RNDSIZE,
    parameter int RND_W   = DEF_RND_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               beat_en,
    input  logic [RND_W-1:0]   rnd,
    output logic [RNDSIZE-1:0] dp_rnd,
    output logic               last_beat
);

    localparam int NBEATS = RNDSIZE / RND_W;
    localparam int BEAT_W = cnt_width(NBEATS);

    logic [BEAT_W-1:0]  r_beat_cnt;
    logic [RNDSIZE-1:0] r_dp_rnd;

    assign last_beat = (r_beat_cnt == BEAT_W'(NBEATS - 1));
    assign dp_rnd    = r_dp_rnd;

    // Every slot is rewritten once per frame, so no stale beat survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_dp_rnd   <= '0;
        end else if (clear) begin
            r_beat_cnt <= '0;
        end else if (beat_en) begin
            r_dp_rnd[r_beat_cnt*RND_W +: RND_W] <= rnd;
            r_beat_cnt <= last_beat ? '0 : r_beat_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_frame_sequencer.sv
// ============================================================================
// Module   : display_frame_sequencer
// Purpose  : Sequences FRAMES display frames per message: gather random beats,
//            wait the datapath latency, present the captured frame.
//            Optional abort input enabled by DISPLAY_SEQ_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_frame_sequencer
    import display_pkg::*;
#(
    parameter int NB_SEG  = DEF_NB_SEG,
    parameter int RNDSIZE = DEF_RNDSIZE,
    parameter int RND_W   = DEF_RND_W,
    parameter int NB_PIX  = DEF_NB_PIX,
    parameter int FRAMES  = DEF_FRAMES,
    parameter int DP_LAT  = DEF_DP_LAT
) (
    input  logic               clk,
    input  logic               rst,
`ifdef DISPLAY_SEQ_ABORT_EN
    input  logic               abort,
`endif
    input  logic               msg_valid,
    output logic               msg_ready,
    input  logic [NB_SEG-1:0]  msg,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    input  logic [RND_W-1:0]   rnd,
    output logic [NB_SEG-1:0]  dp_msg,
    output logic [RNDSIZE-1:0] dp_rnd,
    output logic               dp_z,
    input  logic [NB_PIX-1:0]  dp_pix,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [NB_PIX-1:0]  pix,
    output logic               busy,
    output logic               done
);

    localparam int FRAME_W = cnt_width(FRAMES);
    localparam int EVAL_W  = cnt_width(DP_LAT + 1);

    state_t             r_state;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [EVAL_W-1:0]  r_eval_cnt;
    logic [NB_SEG-1:0]  r_dp_msg;
    logic [NB_PIX-1:0]  r_pix;
    logic               r_done;
    logic               r_abort_pend;

    logic w_abort;
    logic w_msg_xfer;
    logic w_beat_en;
    logic w_last_beat;

`ifdef DISPLAY_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_msg_xfer = msg_valid && (r_state == ST_IDLE);
    // A beat arriving together with abort is dropped along with the frame.
    assign w_beat_en  = rnd_valid && (r_state == ST_GATHER) && !w_abort;

    rnd_packer #(
        .RNDSIZE (RNDSIZE),
        .RND_W   (RND_W)
    ) u_rnd_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_msg_xfer),
        .beat_en   (w_beat_en),
        .rnd       (rnd),
        .dp_rnd    (dp_rnd),
        .last_beat (w_last_beat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_frame_cnt  <= '0;
            r_eval_cnt   <= '0;
            r_dp_msg     <= '0;
            r_pix        <= '0;
            r_done       <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (msg_valid) begin
                        r_dp_msg     <= msg;
                        r_frame_cnt  <= '0;
                        r_abort_pend <= 1'b0;
                        r_state      <= ST_GATHER;
                    end
                end
                ST_GATHER: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_beat_en && w_last_beat) begin
                        r_eval_cnt <= '0;
                        r_state    <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end else if (r_eval_cnt == EVAL_W'(DP_LAT)) begin
                        r_pix   <= dp_pix;
                        r_state <= ST_OUT;
                    end else begin
                        r_eval_cnt <= r_eval_cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    // Abort here is deferred until the presented frame is taken.
                    if (w_abort) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (pix_ready) begin
                        if (w_abort || r_abort_pend) begin
                            r_abort_pend <= 1'b0;
                            r_state      <= ST_IDLE;
                        end else if (r_frame_cnt == FRAME_W'(FRAMES - 1)) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                            r_state     <= ST_GATHER;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign msg_ready = (r_state == ST_IDLE);
    assign rnd_ready = (r_state == ST_GATHER);
    assign pix_valid = (r_state == ST_OUT);
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign dp_msg    = r_dp_msg;
    assign pix       = r_pix;
    assign dp_z      = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_display_frame_sequencer.sv
// ============================================================================
// Module   : tb_display_frame_sequencer
// Purpose  : Randomized self-checking bench for display_frame_sequencer
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_display_frame_sequencer;

    localparam int NB_SEG  = 28;
    localparam int RNDSIZE = 16;
    localparam int RND_W   = 8;
    localparam int NB_PIX  = 64;
    localparam int FRAMES  = 3;
    localparam int DP_LAT  = 2;
    localparam int NBEATS  = RNDSIZE / RND_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               abort = 1'b0;
    logic               msg_valid = 1'b0;
    logic [NB_SEG-1:0]  msg = '0;
    logic               rnd_valid = 1'b0;
    logic [RND_W-1:0]   rnd = '0;
    logic               pix_ready = 1'b0;
    logic [NB_PIX-1:0]  dp_pix;
    logic               msg_ready, rnd_ready, dp_z, pix_valid, busy, done;
    logic [NB_SEG-1:0]  dp_msg;
    logic [RNDSIZE-1:0] dp_rnd;
    logic [NB_PIX-1:0]  pix;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: the cycle number makes the capture instant visible.
    function automatic logic [NB_PIX-1:0] pix_fn(input int c, input logic [NB_SEG-1:0] m,
                                                 input logic [RNDSIZE-1:0] r);
        return {4'hA, c[15:0], r, m};
    endfunction

    assign dp_pix = pix_fn(cyc, dp_msg, dp_rnd);

    display_frame_sequencer #(
        .NB_SEG (NB_SEG), .RNDSIZE (RNDSIZE), .RND_W (RND_W),
        .NB_PIX (NB_PIX), .FRAMES (FRAMES), .DP_LAT (DP_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DISPLAY_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg       (msg),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .rnd       (rnd),
        .dp_msg    (dp_msg),
        .dp_rnd    (dp_rnd),
        .dp_z      (dp_z),
        .dp_pix    (dp_pix),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix       (pix),
        .busy      (busy),
        .done      (done)
    );

    // Reference model: message in progress, beats taken this frame,
    // cycles spent waiting on the datapath, frames delivered.
    bit                 in_seq, pend, exp_done;
    int                 nb, since, frames, out_wait, done_cnt;
    logic [NB_SEG-1:0]  exp_msg;
    logic [RNDSIZE-1:0] exp_rnd;
    logic [NB_PIX-1:0]  exp_pix;
    logic [RNDSIZE-1:0] obs_rnd[$];

    // Stimulus controls
    int p_msg, p_rnd, p_pix, p_abort;
    bit gap5, bp10, dir_beats, fix_msg, one_msg, abort_now;
    int beat_k;
    logic [RND_W-1:0] next_beat;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        bit g, e, o;
        g = in_seq && (nb < NBEATS);
        e = in_seq && (nb == NBEATS) && (since <= DP_LAT);
        o = in_seq && (nb == NBEATS) && (since > DP_LAT);
        chk("msg_ready", msg_ready, !in_seq);
        chk("rnd_ready", rnd_ready, g);
        chk("pix_valid", pix_valid, o);
        chk("busy",      busy,      in_seq);
        chk("done",      done,      exp_done);
        chk("dp_z",      dp_z,      1'b0);
        chk("dp_msg",    dp_msg,    exp_msg);
        chk("dp_rnd",    dp_rnd,    exp_rnd);
        chk("pix",       pix,       exp_pix);
        if (e && since == 0) obs_rnd.push_back(dp_rnd);
        if (done) done_cnt++;
    endtask

    task automatic advance_beat();
        beat_k++;
        next_beat = dir_beats ? RND_W'(8'h11 * (beat_k + 1)) : RND_W'($urandom);
    endtask

    task automatic drive_and_predict();
        bit g, e;
        msg_valid = ($urandom_range(99) < p_msg);
        msg       = fix_msg ? 28'h0ABCDEF : NB_SEG'($urandom);
        rnd_valid = gap5 ? (cyc % 5 == 0) : ($urandom_range(99) < p_rnd);
        rnd       = next_beat;
        pix_ready = bp10 ? (out_wait >= 10) : ($urandom_range(99) < p_pix);
`ifdef DISPLAY_SEQ_ABORT_EN
        abort     = abort_now || ($urandom_range(99) < p_abort);
`else
        abort     = 1'b0;
`endif
        abort_now = 1'b0;

        g = in_seq && (nb < NBEATS);
        e = in_seq && (nb == NBEATS) && (since <= DP_LAT);
        exp_done = 1'b0;
        if (!in_seq) begin
            if (msg_valid) begin
                in_seq = 1; exp_msg = msg; nb = 0; frames = 0; pend = 0; out_wait = 0;
                if (one_msg) p_msg = 0;
            end
        end else if (g) begin
            if (abort) in_seq = 0;
            else if (rnd_valid) begin
                exp_rnd[nb*RND_W +: RND_W] = rnd;
                nb++;
                since = 0;
                advance_beat();
            end
        end else if (e) begin
            if (abort) in_seq = 0;
            else begin
                if (since == DP_LAT) exp_pix = pix_fn(cyc, exp_msg, exp_rnd);
                since++;
            end
        end else begin
            if (abort) pend = 1;
            if (pix_ready) begin
                out_wait = 0;
                if (pend) begin
                    in_seq = 0; pend = 0;
                end else begin
                    frames++;
                    if (frames == FRAMES) begin in_seq = 0; exp_done = 1; end
                    else nb = 0;
                end
            end else begin
                out_wait++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        drive_and_predict();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; msg_valid = 0; rnd_valid = 0; pix_ready = 0; abort = 0;
        in_seq = 0; pend = 0; exp_done = 0; nb = 0; since = 0; frames = 0; out_wait = 0;
        exp_msg = '0; exp_rnd = '0; exp_pix = '0;
        #1 check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_directed(input bit gapped, input bit backpressure);
        p_msg = 100; p_rnd = 100; p_pix = 100; p_abort = 0;
        gap5 = gapped; bp10 = backpressure; dir_beats = 1; fix_msg = 1; one_msg = 1;
        beat_k = 0; next_beat = 8'h11;
        obs_rnd.delete();
    endtask

    task automatic run_to_done(input string tag, input int budget);
        int target, n;
        target = done_cnt + 1;
        n = 0;
        while (done_cnt < target && n < budget) begin step(); n++; end
        chk(tag, n < budget, 1'b1);
        step();
    endtask

    task automatic check_frames(input string tag);
        chk({tag, "_nframes"}, obs_rnd.size(), FRAMES);
        if (obs_rnd.size() == FRAMES) begin
            chk({tag, "_f0"}, obs_rnd[0], 16'h2211);
            chk({tag, "_f1"}, obs_rnd[1], 16'h4433);
            chk({tag, "_f2"}, obs_rnd[2], 16'h6655);
        end
    endtask

    initial begin
        int n, d0;
        abort_now = 0; done_cnt = 0;
        do_reset();

        // Back-to-back transfers, three frames of fixed beats
        set_directed(0, 0);
        d0 = done_cnt;
        run_to_done("timeout_basic", 100);
        chk("basic_done_pulses", done_cnt - d0, 1);
        check_frames("basic");

        // Gapped beats with 10-cycle output backpressure each frame
        set_directed(1, 1);
        run_to_done("timeout_gapped", 400);
        check_frames("gapped");

        // Reset during second-frame EVAL, then a fresh message
        set_directed(0, 0);
        n = 0;
        while (!(frames == 1 && nb == NBEATS && since == 1) && n < 100) begin step(); n++; end
        chk("timeout_reach_eval2", n < 100, 1'b1);
        do_reset();
        set_directed(0, 0);
        d0 = done_cnt;
        run_to_done("timeout_after_rst", 100);
        chk("after_rst_done_pulses", done_cnt - d0, 1);
        check_frames("after_rst");

`ifdef DISPLAY_SEQ_ABORT_EN
        // Abort during gather of the second frame
        set_directed(0, 0);
        d0 = done_cnt;
        n = 0;
        while (!(frames == 1 && nb == 1) && n < 100) begin step(); n++; end
        chk("timeout_reach_gather2", n < 100, 1'b1);
        abort_now = 1;
        for (int i = 0; i < 12; i++) step();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_frames_seen", obs_rnd.size(), 1);
`endif

        // Long randomized run
        p_msg = 30; p_rnd = 60; p_pix = 60; gap5 = 0; bp10 = 0;
        dir_beats = 0; fix_msg = 0; one_msg = 0; next_beat = RND_W'($urandom);
`ifdef DISPLAY_SEQ_ABORT_EN
        p_abort = 2;
`else
        p_abort = 0;
`endif
        for (int i = 0; i < 3000; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
